// File: rtl/dds_sin_cos_gen.sv
// Dual-channel DDS: per-channel 8-bit phase accumulator, folded quarter-wave
// sine lookup (255-scaled) and signed amplitude multiply into Q3.13 samples.
module dds_sin_cos_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [7:0]  amp_sin,
    input  logic [7:0]  amp_cos,
    input  logic [7:0]  phase_sin,
    input  logic [7:0]  phase_cos,
    input  logic [5:0]  freq_sen,
    input  logic [5:0]  freq_cos,
    output logic [15:0] cosine_out,
    output logic [15:0] sine_out
);

    // round(255*sin(2*pi*k/256)) for k = 0..64
    function automatic logic [7:0] quarter_sin(input logic [6:0] idx);
        logic [7:0] q;
        case (idx)
            7'd0:  q = 8'd0;   7'd1:  q = 8'd6;   7'd2:  q = 8'd13;  7'd3:  q = 8'd19;  7'd4:  q = 8'd25;
            7'd5:  q = 8'd31;  7'd6:  q = 8'd37;  7'd7:  q = 8'd44;  7'd8:  q = 8'd50;  7'd9:  q = 8'd56;
            7'd10: q = 8'd62;  7'd11: q = 8'd68;  7'd12: q = 8'd74;  7'd13: q = 8'd80;  7'd14: q = 8'd86;
            7'd15: q = 8'd92;  7'd16: q = 8'd98;  7'd17: q = 8'd103; 7'd18: q = 8'd109; 7'd19: q = 8'd115;
            7'd20: q = 8'd120; 7'd21: q = 8'd126; 7'd22: q = 8'd131; 7'd23: q = 8'd136; 7'd24: q = 8'd142;
            7'd25: q = 8'd147; 7'd26: q = 8'd152; 7'd27: q = 8'd157; 7'd28: q = 8'd162; 7'd29: q = 8'd167;
            7'd30: q = 8'd171; 7'd31: q = 8'd176; 7'd32: q = 8'd180; 7'd33: q = 8'd185; 7'd34: q = 8'd189;
            7'd35: q = 8'd193; 7'd36: q = 8'd197; 7'd37: q = 8'd201; 7'd38: q = 8'd205; 7'd39: q = 8'd208;
            7'd40: q = 8'd212; 7'd41: q = 8'd215; 7'd42: q = 8'd219; 7'd43: q = 8'd222; 7'd44: q = 8'd225;
            7'd45: q = 8'd228; 7'd46: q = 8'd231; 7'd47: q = 8'd233; 7'd48: q = 8'd236; 7'd49: q = 8'd238;
            7'd50: q = 8'd240; 7'd51: q = 8'd242; 7'd52: q = 8'd244; 7'd53: q = 8'd246; 7'd54: q = 8'd247;
            7'd55: q = 8'd249; 7'd56: q = 8'd250; 7'd57: q = 8'd251; 7'd58: q = 8'd252; 7'd59: q = 8'd253;
            7'd60: q = 8'd254; 7'd61: q = 8'd254; 7'd62: q = 8'd255; 7'd63: q = 8'd255; 7'd64: q = 8'd255;
            default: q = 8'd0;
        endcase
        return q;
    endfunction

    // Odd quadrants read the quarter table mirrored (64 - idx), the lower half-wave is negated.
    function automatic logic signed [8:0] sin_lut(input logic [7:0] addr);
        logic [6:0]        idx;
        logic signed [8:0] mag;
        idx = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
        mag = {1'b0, quarter_sin(idx)};
        return addr[7] ? -mag : mag;
    endfunction

    logic [7:0]         acc_sin;
    logic [7:0]         acc_cos;
    logic signed [8:0]  lut_sin;
    logic signed [8:0]  lut_cos;
    logic [7:0]         addr_sin;
    logic [7:0]         addr_cos;
    logic signed [15:0] prod_sin;
    logic signed [15:0] prod_cos;

    // Cosine is the sine table read a quarter turn ahead.
    assign addr_sin = acc_sin + phase_sin;
    assign addr_cos = acc_cos + phase_cos + 8'd64;

    // The full product always fits in 16 bits, so a 16-bit multiply gives the exact low half.
    assign prod_sin = $signed({{8{amp_sin[7]}}, amp_sin}) * $signed({{7{lut_sin[8]}}, lut_sin});
    assign prod_cos = $signed({{8{amp_cos[7]}}, amp_cos}) * $signed({{7{lut_cos[8]}}, lut_cos});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_sin    <= 8'd0;
            acc_cos    <= 8'd0;
            lut_sin    <= 9'sd0;
            lut_cos    <= 9'sd0;
            sine_out   <= 16'd0;
            cosine_out <= 16'd0;
        end else if (en) begin
            acc_sin    <= load ? 8'd0 : acc_sin + {2'b00, freq_sen};
            acc_cos    <= load ? 8'd0 : acc_cos + {2'b00, freq_cos};
            lut_sin    <= sin_lut(addr_sin);
            lut_cos    <= sin_lut(addr_cos);
            sine_out   <= prod_sin;
            cosine_out <= prod_cos;
        end
    end

endmodule

// File: tb/tb_dds_sin_cos_gen.sv
// Directed bench for dds_sin_cos_gen: hand-picked sample points plus a
// floating-point sine reference for the sweeps between them.
module tb_dds_sin_cos_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [7:0]  amp_sin;
    logic [7:0]  amp_cos;
    logic [7:0]  phase_sin;
    logic [7:0]  phase_cos;
    logic [5:0]  freq_sen;
    logic [5:0]  freq_cos;
    logic [15:0] cosine_out;
    logic [15:0] sine_out;

    int errors = 0;
    int checks = 0;

    dds_sin_cos_gen dut (
        .clk(clk), .rst(rst), .en(en), .load(load),
        .amp_sin(amp_sin), .amp_cos(amp_cos),
        .phase_sin(phase_sin), .phase_cos(phase_cos),
        .freq_sen(freq_sen), .freq_cos(freq_cos),
        .cosine_out(cosine_out), .sine_out(sine_out)
    );

    always #5 clk = ~clk;

    function automatic int s_ref(int k);
        real r;
        r = 255.0 * $sin(2.0 * 3.14159265358979 * real'(k % 256) / 256.0);
        return $rtoi($floor(r + 0.5));
    endfunction

    function automatic int c_ref(int k);
        return s_ref(k + 64);
    endfunction

    function automatic logic [15:0] scale(int amp, int t);
        int p;
        p = amp * t;
        return p[15:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_inputs(int as, int ac, int ps, int pc, int fs, int fc);
        amp_sin   = 8'(as);
        amp_cos   = 8'(ac);
        phase_sin = 8'(ps);
        phase_cos = 8'(pc);
        freq_sen  = 6'(fs);
        freq_cos  = 6'(fc);
    endtask

    task automatic test_reset;
        set_inputs(127, 127, 10, 20, 5, 7);
        rst  = 1'b0;
        en   = 1'b1;
        load = 1'b0;
        repeat (3) tick();
        checks++;
        if (sine_out !== 16'h0000) begin
            errors++; $display("FAIL reset_sine got=%h exp=0000", sine_out);
        end
        checks++;
        if (cosine_out !== 16'h0000) begin
            errors++; $display("FAIL reset_cos got=%h exp=0000", cosine_out);
        end
    endtask

    task automatic test_basic;
        logic [15:0] es, ec;
        set_inputs(127, 127, 0, 0, 1, 1);
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 322; n++) begin
            tick();
            if (n == 1 || n == 2) begin
                checks++;
                if (sine_out !== 16'h0000) begin
                    errors++; $display("FAIL basic_sine_start n=%0d got=%h exp=0000", n, sine_out);
                end
            end
            if (n == 1) begin
                checks++;
                if (cosine_out !== 16'h0000) begin
                    errors++; $display("FAIL basic_cos_edge1 got=%h exp=0000", cosine_out);
                end
            end
            if (n == 2) begin
                checks++;
                if (cosine_out !== 16'h7E81) begin
                    errors++; $display("FAIL basic_cos_peak got=%h exp=7e81", cosine_out);
                end
            end
            if (n == 66 || n == 322) begin
                checks++;
                if (sine_out !== 16'h7E81) begin
                    errors++; $display("FAIL basic_sine_peak n=%0d got=%h exp=7e81", n, sine_out);
                end
            end
            if (n == 130) begin
                checks++;
                if (cosine_out !== 16'h817F) begin
                    errors++; $display("FAIL basic_cos_trough got=%h exp=817f", cosine_out);
                end
            end
            if (n >= 2) begin
                es = scale(127, s_ref(n - 2));
                ec = scale(127, c_ref(n - 2));
                checks++;
                if (sine_out !== es || cosine_out !== ec) begin
                    errors++;
                    $display("FAIL basic_sweep n=%0d got=%h/%h exp=%h/%h", n, sine_out, cosine_out, es, ec);
                end
            end
        end
    endtask

    task automatic test_freq;
        logic [15:0] es, ec;
        set_inputs(64, 64, 0, 0, 8, 12);
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (n == 10 || n == 42) begin
                checks++;
                if (sine_out !== 16'h3FC0) begin
                    errors++; $display("FAIL freq_sine_peak n=%0d got=%h exp=3fc0", n, sine_out);
                end
            end
            if (n == 26) begin
                checks++;
                if (sine_out !== 16'hC040) begin
                    errors++; $display("FAIL freq_sine_trough got=%h exp=c040", sine_out);
                end
            end
            if (n == 2 || n == 66) begin
                checks++;
                if (cosine_out !== 16'h3FC0) begin
                    errors++; $display("FAIL freq_cos_peak n=%0d got=%h exp=3fc0", n, cosine_out);
                end
            end
            if (n >= 2) begin
                es = scale(64, s_ref(8 * (n - 2)));
                ec = scale(64, c_ref(12 * (n - 2)));
                checks++;
                if (sine_out !== es || cosine_out !== ec) begin
                    errors++;
                    $display("FAIL freq_sweep n=%0d got=%h/%h exp=%h/%h", n, sine_out, cosine_out, es, ec);
                end
            end
        end
    endtask

    task automatic test_phase;
        logic [15:0] es, ec;
        set_inputs(31, 32, 64, 128, 16, 4);
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            tick();
            if (n == 2) begin
                checks++;
                if (sine_out !== 16'h1EE1) begin
                    errors++; $display("FAIL phase_sine_start got=%h exp=1ee1", sine_out);
                end
                checks++;
                if (cosine_out !== 16'hE020) begin
                    errors++; $display("FAIL phase_cos_start got=%h exp=e020", cosine_out);
                end
            end
            if (n >= 2) begin
                es = scale(31, s_ref(16 * (n - 2) + 64));
                ec = scale(32, c_ref(4 * (n - 2) + 128));
                checks++;
                if (sine_out !== es || cosine_out !== ec) begin
                    errors++;
                    $display("FAIL phase_sweep n=%0d got=%h/%h exp=%h/%h", n, sine_out, cosine_out, es, ec);
                end
            end
        end
    endtask

    task automatic test_enable;
        logic [15:0] es, ec;
        set_inputs(127, 127, 0, 0, 1, 3);
        do_reset();
        en = 1'b1;
        repeat (40) tick();
        en   = 1'b0;
        load = 1'b1;
        es = scale(127, s_ref(38));
        ec = scale(127, c_ref(3 * 38));
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (sine_out !== es || cosine_out !== ec) begin
                errors++;
                $display("FAIL enable_hold i=%0d got=%h/%h exp=%h/%h", i, sine_out, cosine_out, es, ec);
            end
        end
        load = 1'b0;
        en   = 1'b1;
        for (int n = 41; n <= 70; n++) begin
            tick();
            es = scale(127, s_ref(n - 2));
            ec = scale(127, c_ref(3 * (n - 2)));
            checks++;
            if (sine_out !== es || cosine_out !== ec) begin
                errors++;
                $display("FAIL enable_resume n=%0d got=%h/%h exp=%h/%h", n, sine_out, cosine_out, es, ec);
            end
        end
    endtask

    task automatic test_load;
        logic [15:0] es, ec;
        set_inputs(127, 127, 0, 0, 5, 3);
        do_reset();
        en = 1'b1;
        repeat (30) tick();
        load     = 1'b1;
        freq_sen = 6'd1;
        freq_cos = 6'd1;
        tick();
        load = 1'b0;
        tick();
        es = scale(127, s_ref(150));
        ec = scale(127, c_ref(90));
        checks++;
        if (sine_out !== es || cosine_out !== ec) begin
            errors++;
            $display("FAIL load_edge1 got=%h/%h exp=%h/%h", sine_out, cosine_out, es, ec);
        end
        for (int k = 2; k <= 70; k++) begin
            tick();
            if (k == 2) begin
                checks++;
                if (sine_out !== 16'h0000 || cosine_out !== 16'h7E81) begin
                    errors++;
                    $display("FAIL load_restart got=%h/%h exp=0000/7e81", sine_out, cosine_out);
                end
            end
            es = scale(127, s_ref(k - 2));
            ec = scale(127, c_ref(k - 2));
            checks++;
            if (sine_out !== es || cosine_out !== ec) begin
                errors++;
                $display("FAIL load_sweep k=%0d got=%h/%h exp=%h/%h", k, sine_out, cosine_out, es, ec);
            end
        end
    endtask

    task automatic test_neg_amp;
        set_inputs(-128, -128, 192, 0, 0, 0);
        do_reset();
        en = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (cosine_out !== 16'h8080) begin
                errors++; $display("FAIL neg_amp_cos i=%0d got=%h exp=8080", i, cosine_out);
            end
            checks++;
            if (sine_out !== 16'h7F80) begin
                errors++; $display("FAIL neg_amp_sine i=%0d got=%h exp=7f80", i, sine_out);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [15:0] es, ec;
        set_inputs(127, 127, 0, 0, 1, 1);
        do_reset();
        en = 1'b1;
        repeat (20) tick();
        es = scale(127, s_ref(18));
        ec = scale(127, c_ref(18));
        checks++;
        if (sine_out !== es || cosine_out !== ec) begin
            errors++;
            $display("FAIL async_pre got=%h/%h exp=%h/%h", sine_out, cosine_out, es, ec);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (sine_out !== 16'h0000 || cosine_out !== 16'h0000) begin
            errors++;
            $display("FAIL async_clear got=%h/%h exp=0000/0000", sine_out, cosine_out);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            es = (n >= 2) ? scale(127, s_ref(n - 2)) : 16'h0000;
            ec = (n >= 2) ? scale(127, c_ref(n - 2)) : 16'h0000;
            checks++;
            if (sine_out !== es || cosine_out !== ec) begin
                errors++;
                $display("FAIL async_restart n=%0d got=%h/%h exp=%h/%h", n, sine_out, cosine_out, es, ec);
            end
        end
    endtask

    initial begin
        rst  = 1'b0;
        en   = 1'b0;
        load = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_freq();
        test_phase();
        test_enable();
        test_load();
        test_neg_amp();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
